// File: rtl/edge_pkg.sv
// Shared types and frame-geometry helpers for the edge-detection accelerator.
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } fetch_state_t;

  // Four 8-bit pixels are packed into each 32-bit memory word.
  function automatic int row_width(input int width);
    return width / 4;
  endfunction

  function automatic int words(input int width, input int height);
    return (width / 4) * height;
  endfunction

  // Number of bits needed to hold the values 0..max_val.
  function automatic int cnt_bits(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One row of 32-bit words: simple dual-port RAM, synchronous read, write-first on collision.
module line_buffer #(
  parameter int DEPTH = 88,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // The bypass only matters for one-word rows, where a back-to-back consume
  // reads the column that is being retired in the same cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/row_fetch.sv
// Memory-side front end: streams a frame through two line buffers and presents
// a three-row window per consume; forwards result writes to the output region.
module row_fetch
  import edge_pkg::*;
#(
  parameter int WIDTH    = 352,
  parameter int HEIGHT   = 288,
  parameter int OUT_BASE = 25344
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        acc_en,
  input  logic        acc_we,
  input  logic [31:0] acc_dataW,
  output logic [31:0] dataRa,
  output logic [31:0] dataRb,
  output logic [31:0] dataRc,
  output logic        row_cached,
  output logic [15:0] mem_addr,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_dataW,
  input  logic [31:0] mem_dataR,
  output logic [1:0]  dbg_state
);

  localparam int RW  = row_width(WIDTH);
  localparam int NW  = words(WIDTH, HEIGHT);
  localparam int CW  = cnt_bits(RW - 1);
  localparam int FW  = cnt_bits(RW);
  localparam int RB  = cnt_bits(HEIGHT - 1);
  localparam int WW  = cnt_bits(NW);

  localparam logic [CW-1:0] COL_LAST = CW'(RW - 1);
  localparam logic [FW-1:0] FILL_END = FW'(RW);
  localparam logic [RB-1:0] ROW_LAST = RB'(HEIGHT - 1);
  localparam logic [WW-1:0] WR_LAST  = WW'(NW - 1);
  localparam logic [WW-1:0] WR_END   = WW'(NW);

  fetch_state_t  state;
  logic [CW-1:0] col, col_d;
  logic [RB-1:0] row;
  logic [FW-1:0] fill;
  logic [WW-1:0] wr;
  logic          cons_done, cons_d, rd_d;

  logic          consume, write, rd_next;
  logic [31:0]   a_q, b_q;
  logic          buf_we;
  logic [CW-1:0] buf_waddr;
  logic [31:0]   a_wdata, b_wdata;

  // Accelerator handshake: acc_en is a request that is accepted in the cycle it
  // is seen (no back-pressure); acc_we selects write (1) or consume (0).
  // Requests beyond the end of the frame are dropped silently.
  assign consume   = (state == STREAM) && acc_en && !acc_we && !cons_done;
  assign write     = (state == STREAM) && acc_en && acc_we && (wr != WR_END);
  assign rd_next   = consume && (row != ROW_LAST);
  assign dbg_state = state;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'd0;
    mem_dataW = 32'd0;
    case (state)
      FILL: begin
        if (fill != FILL_END) begin
          mem_en   = 1'b1;
          mem_addr = 16'(fill);
        end
      end
      STREAM: begin
        if (write) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = 16'(OUT_BASE) + 16'(wr);
          mem_dataW = acc_dataW;
        end else if (rd_next) begin
          mem_en   = 1'b1;
          mem_addr = (16'(row) + 16'd1) * 16'(RW) + 16'(col);
        end
      end
      default: ;
    endcase
  end

  // FILL loads row 0 into B while clearing A; STREAM retires a column one
  // cycle after its consume (A takes old B, B takes the newly read row).
  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = '0;
    a_wdata   = 32'd0;
    b_wdata   = 32'd0;
    if ((state == FILL) && (fill != '0)) begin
      buf_we    = 1'b1;
      buf_waddr = CW'(fill - 1'b1);
      b_wdata   = mem_dataR;
    end else if (cons_d) begin
      buf_we    = 1'b1;
      buf_waddr = col_d;
      a_wdata   = b_q;
      b_wdata   = rd_d ? mem_dataR : 32'd0;
    end
  end

  line_buffer #(.DEPTH(RW), .AW(CW)) u_buf_a (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (a_wdata),
    .re    (consume),
    .raddr (col),
    .rdata (a_q)
  );

  line_buffer #(.DEPTH(RW), .AW(CW)) u_buf_b (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (b_wdata),
    .re    (consume),
    .raddr (col),
    .rdata (b_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      col        <= '0;
      col_d      <= '0;
      row        <= '0;
      fill       <= '0;
      wr         <= '0;
      cons_done  <= 1'b0;
      cons_d     <= 1'b0;
      rd_d       <= 1'b0;
      dataRa     <= 32'd0;
      dataRb     <= 32'd0;
      dataRc     <= 32'd0;
      row_cached <= 1'b0;
    end else begin
      cons_d <= consume;
      rd_d   <= rd_next;
      col_d  <= col;
      if (cons_d) begin
        dataRa <= a_q;
        dataRb <= b_q;
        dataRc <= rd_d ? mem_dataR : 32'd0;
      end
      case (state)
        IDLE: begin
          row_cached <= 1'b0;
          if (start) begin
            col       <= '0;
            row       <= '0;
            fill      <= '0;
            wr        <= '0;
            cons_done <= 1'b0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (fill == FILL_END) begin
            state      <= STREAM;
            row_cached <= 1'b1;
          end else begin
            fill <= fill + 1'b1;
          end
        end
        STREAM: begin
          if (consume) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) cons_done <= 1'b1;
              else                 row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
          if (write) begin
            wr <= wr + 1'b1;
            if (wr == WR_LAST) begin
              state      <= DONE;
              row_cached <= 1'b0;
            end
          end
        end
        DONE: begin
          row_cached <= 1'b0;
          if (!start) begin
            state  <= IDLE;
            dataRa <= 32'd0;
            dataRb <= 32'd0;
            dataRc <= 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
